// File: rtl/mem_port_arbiter_if.sv
// Port bundle for mem_port_arbiter: I-fetch side, D-access side and the shared RAM port.
// The slave modport is the arbiter's view; the master modport is the requesters/RAM view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rsp_data;

  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [DATA_W-1:0] d_req_wdata;
  logic [MASK_W-1:0] d_req_wmask;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wmask,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and data access, one transaction at a time, D priority.
// Define ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT consecutive lost arbitrations.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e            state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              memReqValid_q;
  logic              iRspValid_q;
  logic [DATA_W-1:0] iRspData_q;
  logic              dRspValid_q;
  logic [DATA_W-1:0] dRspData_q;

  logic idle;
  logic forceI;
  logic grantD;
  logic grantI;

  // Readies are combinational in IDLE and held low while reset is asserted.
  assign idle = rst && (state_q == IDLE);

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starveCnt_q;
  assign forceI = (starveCnt_q == 4'(STARVE_LIMIT)) && bus.i_req_valid;
`else
  assign forceI = 1'b0;
`endif

  assign grantD = idle && bus.d_req_valid && !forceI;
  assign grantI = idle && bus.i_req_valid && (!bus.d_req_valid || forceI);

  assign bus.d_req_ready   = grantD;
  assign bus.i_req_ready   = grantI;
  assign bus.mem_req_valid = memReqValid_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wmask = wmask_q;
  assign bus.i_rsp_valid   = iRspValid_q;
  assign bus.i_rsp_data    = iRspData_q;
  assign bus.d_rsp_valid   = dRspValid_q;
  assign bus.d_rsp_data    = dRspData_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_I;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      memReqValid_q <= 1'b0;
      iRspValid_q   <= 1'b0;
      iRspData_q    <= '0;
      dRspValid_q   <= 1'b0;
      dRspData_q    <= '0;
`ifdef ARB_STARVE_GUARD_EN
      starveCnt_q   <= '0;
`endif
    end else begin
      iRspValid_q <= 1'b0;
      dRspValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantD) begin
            owner_q       <= OWN_D;
            addr_q        <= bus.d_req_addr;
            we_q          <= bus.d_req_we;
            wdata_q       <= bus.d_req_wdata;
            wmask_q       <= bus.d_req_wmask;
            memReqValid_q <= 1'b1;
            state_q       <= ISSUE;
          end else if (grantI) begin
            owner_q       <= OWN_I;
            addr_q        <= bus.i_req_addr;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            memReqValid_q <= 1'b1;
            state_q       <= ISSUE;
          end
`ifdef ARB_STARVE_GUARD_EN
          if (grantD && bus.i_req_valid) begin
            starveCnt_q <= starveCnt_q + 4'd1;
          end else if (grantI) begin
            starveCnt_q <= '0;
          end
`endif
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            memReqValid_q <= 1'b0;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (owner_q == OWN_D) begin
              dRspValid_q <= 1'b1;
              dRspData_q  <= we_q ? '0 : bus.mem_rsp_data;
            end else begin
              iRspValid_q <= 1'b1;
              iRspData_q  <= bus.mem_rsp_data;
            end
            state_q <= IDLE;
          end
        end
        default: begin
          memReqValid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized traffic against a
// transaction-level model of arbitration, RAM handshake and response routing.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checkCount = 0;
  int passCount  = 0;

`ifdef ARB_STARVE_GUARD_EN
  localparam int LIMIT = 4;
`endif

  // Transaction-level model: one pending transfer, its RAM phase, and the response due next cycle.
  bit          busy;
  bit          reqOut;
  bit          rspOut;
  int          rspDelay;
  int          starve;
  bit          pOwnerD;
  logic [63:0] pAddr;
  bit          pWe;
  logic [63:0] pWdata;
  logic [7:0]  pWmask;
  logic [63:0] ramData;
  bit          expIPulse;
  bit          expDPulse;
  logic [63:0] expIData;
  logic [63:0] expDData;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic clearModel();
    busy = 0; reqOut = 0; rspOut = 0; rspDelay = 0; starve = 0;
    expIPulse = 0; expDPulse = 0; pOwnerD = 0; pAddr = '0; pWe = 0;
    pWdata = '0; pWmask = '0; ramData = '0; expIData = '0; expDData = '0;
  endtask

  task automatic clearInputs();
    bus.i_req_valid = 0; bus.i_req_addr = '0;
    bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_we = 0;
    bus.d_req_wdata = '0; bus.d_req_wmask = '0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
  endtask

  // Holds reset for a few cycles with requests pending; returns at posedge+1 with reset released.
  task automatic doReset();
    rst = 1'b0;
    clearInputs();
    bus.i_req_valid = 1;
    bus.d_req_valid = 1;
    repeat (2) @(negedge clk);
    checkOutput("rst_i_req_ready", bus.i_req_ready, 0);
    checkOutput("rst_d_req_ready", bus.d_req_ready, 0);
    checkOutput("rst_mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("rst_mem_req_addr", bus.mem_req_addr, 0);
    checkOutput("rst_i_rsp_valid", bus.i_rsp_valid, 0);
    checkOutput("rst_d_rsp_valid", bus.d_rsp_valid, 0);
    checkOutput("rst_d_rsp_data", bus.d_rsp_data, 0);
    @(posedge clk); #1;
    clearInputs();
    rst = 1'b1;
    clearModel();
  endtask

  // One bench cycle per iteration: drive at posedge+1, check and advance the model at negedge.
  task automatic applyStimulus(input int n, input int pI, input int pD, input int pReady,
                               input int maxDelay, input int spurious,
                               output int iGrantObs, output int grantObs);
    bit expD, expI, forceI;
    iGrantObs = 0;
    grantObs  = 0;
    for (int c = 0; c < n; c++) begin
      if (!bus.i_req_valid && ($urandom % 100) < pI) begin
        bus.i_req_valid = 1;
        bus.i_req_addr  = {$urandom, $urandom};
      end
      if (!bus.d_req_valid && ($urandom % 100) < pD) begin
        bus.d_req_valid = 1;
        bus.d_req_addr  = {$urandom, $urandom};
        bus.d_req_we    = $urandom % 2;
        bus.d_req_wdata = {$urandom, $urandom};
        bus.d_req_wmask = 8'($urandom % 256);
      end
      bus.mem_req_ready = ($urandom % 100) < pReady;
      if (rspOut) begin
        if (rspDelay == 0) begin
          ramData = {$urandom, $urandom};
          bus.mem_rsp_valid = 1;
          bus.mem_rsp_data  = ramData;
        end else begin
          bus.mem_rsp_valid = 0;
          rspDelay--;
        end
      end else begin
        bus.mem_rsp_valid = ($urandom % 100) < spurious;
        bus.mem_rsp_data  = {$urandom, $urandom};
      end

      @(negedge clk);
`ifdef ARB_STARVE_GUARD_EN
      forceI = (starve == LIMIT) && bus.i_req_valid;
`else
      forceI = 0;
`endif
      expD = !busy && bus.d_req_valid && !forceI;
      expI = !busy && bus.i_req_valid && (!bus.d_req_valid || forceI);
      checkOutput("d_req_ready", bus.d_req_ready, expD);
      checkOutput("i_req_ready", bus.i_req_ready, expI);
      checkOutput("mem_req_valid", bus.mem_req_valid, reqOut);
      if (reqOut) begin
        checkOutput("mem_req_addr", bus.mem_req_addr, pAddr);
        checkOutput("mem_req_we", bus.mem_req_we, pWe);
        checkOutput("mem_req_wmask", bus.mem_req_wmask, pWmask);
        if (pOwnerD) checkOutput("mem_req_wdata", bus.mem_req_wdata, pWdata);
      end
      checkOutput("i_rsp_valid", bus.i_rsp_valid, expIPulse);
      checkOutput("d_rsp_valid", bus.d_rsp_valid, expDPulse);
      if (expIPulse) checkOutput("i_rsp_data", bus.i_rsp_data, expIData);
      if (expDPulse) checkOutput("d_rsp_data", bus.d_rsp_data, expDData);

      if (bus.i_req_valid && bus.i_req_ready) iGrantObs++;
      if ((bus.i_req_valid && bus.i_req_ready) || (bus.d_req_valid && bus.d_req_ready)) grantObs++;

      expIPulse = 0;
      expDPulse = 0;
      if (!busy) begin
        if (expD) begin
          busy = 1; reqOut = 1; pOwnerD = 1;
          pAddr = bus.d_req_addr; pWe = bus.d_req_we;
          pWdata = bus.d_req_wdata; pWmask = bus.d_req_wmask;
          if (bus.i_req_valid) starve++;
        end else if (expI) begin
          busy = 1; reqOut = 1; pOwnerD = 0;
          pAddr = bus.i_req_addr; pWe = 0; pWdata = '0; pWmask = '0;
          starve = 0;
        end
      end else if (reqOut) begin
        if (bus.mem_req_ready) begin
          reqOut = 0;
          rspOut = 1;
          rspDelay = $urandom % (maxDelay + 1);
        end
      end else if (rspOut && bus.mem_rsp_valid) begin
        rspOut = 0;
        busy = 0;
        if (pOwnerD) begin
          expDPulse = 1;
          expDData  = pWe ? 64'd0 : ramData;
        end else begin
          expIPulse = 1;
          expIData  = ramData;
        end
      end

      @(posedge clk); #1;
      if (expD) bus.d_req_valid = 0;
      if (expI) bus.i_req_valid = 0;
    end
  endtask

  int iGrants;
  int grants;

  initial begin
    $display("[TB] mem_port_arbiter bench start");
    rst = 1'b0;
    clearInputs();
    clearModel();
    doReset();

    // Fetch only, RAM answers in the first WAIT cycle.
    bus.i_req_valid = 1; bus.i_req_addr = 64'h8000_0000; bus.mem_req_ready = 1;
    @(negedge clk);
    checkOutput("t1_i_req_ready", bus.i_req_ready, 1);
    checkOutput("t1_d_req_ready", bus.d_req_ready, 0);
    @(posedge clk); #1; bus.i_req_valid = 0;
    @(negedge clk);
    checkOutput("t1_mem_req_valid", bus.mem_req_valid, 1);
    checkOutput("t1_mem_req_addr", bus.mem_req_addr, 64'h8000_0000);
    checkOutput("t1_mem_req_we", bus.mem_req_we, 0);
    @(posedge clk); #1; bus.mem_rsp_valid = 1; bus.mem_rsp_data = 64'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("t1_mem_req_drop", bus.mem_req_valid, 0);
    checkOutput("t1_i_rsp_early", bus.i_rsp_valid, 0);
    @(posedge clk); #1; bus.mem_rsp_valid = 0;
    @(negedge clk);
    checkOutput("t1_i_rsp_valid", bus.i_rsp_valid, 1);
    checkOutput("t1_i_rsp_data", bus.i_rsp_data, 64'hDEAD_BEEF);
    checkOutput("t1_d_rsp_valid", bus.d_rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1_i_rsp_pulse", bus.i_rsp_valid, 0);
    @(posedge clk); #1;

    // Store with RAM stalling five cycles; ack data must be zero even if RAM returns data.
    bus.d_req_valid = 1; bus.d_req_addr = 64'h100; bus.d_req_we = 1;
    bus.d_req_wdata = 64'h1122_3344_5566_7788; bus.d_req_wmask = 8'h0F; bus.mem_req_ready = 0;
    @(negedge clk);
    checkOutput("t2_d_req_ready", bus.d_req_ready, 1);
    @(posedge clk); #1; bus.d_req_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("t4_hold_valid", bus.mem_req_valid, 1);
      checkOutput("t4_hold_addr", bus.mem_req_addr, 64'h100);
      @(posedge clk); #1;
    end
    bus.mem_req_ready = 1;
    @(negedge clk);
    checkOutput("t2_mem_req_we", bus.mem_req_we, 1);
    checkOutput("t2_mem_req_wdata", bus.mem_req_wdata, 64'h1122_3344_5566_7788);
    checkOutput("t2_mem_req_wmask", bus.mem_req_wmask, 8'h0F);
    @(posedge clk); #1; bus.mem_req_ready = 0; bus.mem_rsp_valid = 1; bus.mem_rsp_data = 64'h55AA;
    @(negedge clk);
    checkOutput("t4_single_handshake", bus.mem_req_valid, 0);
    @(posedge clk); #1; bus.mem_rsp_valid = 0;
    @(negedge clk);
    checkOutput("t2_d_rsp_valid", bus.d_rsp_valid, 1);
    checkOutput("t2_d_rsp_data", bus.d_rsp_data, 0);
    checkOutput("t2_i_rsp_valid", bus.i_rsp_valid, 0);
    @(posedge clk); #1;

    // Reset while waiting on RAM; the late response must be dropped.
    bus.d_req_valid = 1; bus.d_req_addr = 64'h200; bus.d_req_we = 0; bus.mem_req_ready = 1;
    @(negedge clk);
    checkOutput("t6_d_req_ready", bus.d_req_ready, 1);
    @(posedge clk); #1; bus.d_req_valid = 0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_mem_req_valid", bus.mem_req_valid, 0);
    @(posedge clk); #1; rst = 1'b1; bus.mem_rsp_valid = 1; bus.mem_rsp_data = 64'h77;
    @(negedge clk);
    checkOutput("t6_no_d_rsp", bus.d_rsp_valid, 0);
    @(posedge clk); #1; bus.mem_rsp_valid = 0; bus.i_req_valid = 1; bus.i_req_addr = 64'h40;
    @(negedge clk);
    checkOutput("t6_no_d_rsp_late", bus.d_rsp_valid, 0);
    checkOutput("t6_no_i_rsp_late", bus.i_rsp_valid, 0);
    checkOutput("t6_idle_i_ready", bus.i_req_ready, 1);
    @(posedge clk); #1;

    // Randomized mixed traffic with stalls, response delays and stray RAM responses.
    doReset();
    applyStimulus(1500, 60, 40, 50, 3, 12, iGrants, grants);

    // Both sides continuously requesting, RAM always ready: 3 cycles per transfer.
    doReset();
    applyStimulus(120, 100, 100, 100, 0, 0, iGrants, grants);
    checkOutput("starve_total_grants", grants, 40);
`ifdef ARB_STARVE_GUARD_EN
    checkOutput("starve_i_grants", iGrants, grants / (LIMIT + 1));
`else
    checkOutput("starve_i_grants", iGrants, 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
